// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte
// producers. A producer can lock the transmitter for a multi-byte message so
// that strings never interleave. It also detects a transmitter that never starts.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 4096,
    parameter int LOCK_TIMEOUT  = 65535
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_idle,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       locked,
    output logic                       busy,
    output logic                       err_timeout,
    output logic [15:0]                bytes_sent
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int STW = $clog2(START_TIMEOUT + 1);
    localparam int LTW = $clog2(LOCK_TIMEOUT + 1);

    // Terminal values: a timer equal to these on an active cycle expires at that edge.
    localparam logic [STW-1:0] START_LAST = STW'(START_TIMEOUT - 1);
    localparam logic [LTW-1:0] LOCK_LAST  = LTW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic            cand_found;
    logic [IDW-1:0]  cand_id;
    logic            accept;
    logic            start_to;
    logic            done;
    logic            last_q;
    logic [STW-1:0]  start_timer;
    logic [LTW-1:0]  lock_cnt;
    logic            lock_run;
    logic            lock_expire;

    // Index arithmetic modulo NUM_REQ; works for non-power-of-two counts.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum[IDW-1:0];
    endfunction

    assign tx_start = (state == START);
    assign busy     = (state != IDLE);

    // The lock ages only while we sit in IDLE and the owner has nothing to offer.
    assign lock_run    = (state == IDLE) && locked && !req_valid[grant_id];
    assign lock_expire = lock_run && (lock_cnt == LOCK_LAST);

    // Candidate selection: the lock owner only, or the first valid from the RR pointer.
    always_comb begin
        cand_found = 1'b0;
        cand_id    = '0;
        if (locked) begin
            cand_found = req_valid[grant_id];
            cand_id    = grant_id;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!cand_found && req_valid[wrap_add(rr_ptr, k)]) begin
                    cand_found = 1'b1;
                    cand_id    = wrap_add(rr_ptr, k);
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the combinational accept pulse.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        start_to  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (reset_n && tx_idle && cand_found) begin
                    accept             = 1'b1;
                    req_ready[cand_id] = 1'b1;
                    state_nxt          = START;
                end
            end
            START: begin
                if (!tx_idle) begin
                    state_nxt = WAIT_DONE;
                end else if (start_timer == START_LAST) begin
                    start_to  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (tx_idle) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Byte capture, grant/lock bookkeeping, RR pointer and completion counter.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tx_data     <= 8'h00;
            last_q      <= 1'b0;
            grant_id    <= '0;
            locked      <= 1'b0;
            rr_ptr      <= '0;
            err_timeout <= 1'b0;
            bytes_sent  <= 16'h0000;
        end else begin
            err_timeout <= start_to;
            if (accept) begin
                tx_data  <= req_data[{cand_id, 3'b000} +: 8];
                last_q   <= req_last[cand_id];
                grant_id <= cand_id;
            end
            if (start_to) begin
                locked <= 1'b0;
                rr_ptr <= wrap_add(grant_id, 1);
            end
            if (done) begin
                bytes_sent <= bytes_sent + 16'd1;
                if (last_q) begin
                    locked <= 1'b0;
                    rr_ptr <= wrap_add(grant_id, 1);
                end else begin
                    locked <= 1'b1;
                end
            end
            if (lock_expire) begin
                locked <= 1'b0;
                rr_ptr <= wrap_add(grant_id, 1);
            end
        end
    end

    // Start watchdog: counts cycles spent in START with the core still idle.
    always_ff @(posedge clock) begin
        if (!reset_n || state != START || !tx_idle || start_to) begin
            start_timer <= '0;
        end else begin
            start_timer <= start_timer + 1'b1;
        end
    end

    // Lock watchdog: counts idle cycles while the owner holds the lock without a byte.
    always_ff @(posedge clock) begin
        if (!reset_n || !lock_run || lock_expire) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt + 1'b1;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
- Sits between producer blocks (status printers, debug dumpers) and the UART TX core.
- Each producer offers bytes on a valid/ready handshake. A producer can lock the transmitter for a multi-byte message so strings never interleave.
- The block sequences the TX core's start/complete handshake and detects a transmitter that never starts.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- START_TIMEOUT, 4096, clock cycles to wait for tx_idle to fall after start is asserted.
- LOCK_TIMEOUT, 65535, idle cycles after which a lock whose owner has no valid byte is released.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte.
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the last of its message; 0 requests a lock.
- req_ready  out  NUM_REQ  one-hot accept pulse; transfer occurs when valid&ready.
- tx_start  out  1  start request to TX core, held as a level.
- tx_data  out  8  byte to transmit, stable from accept until next accept.
- tx_idle  in  1  TX core idle/complete flag, high when idle.
- grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester.
- locked  out  1  a lock is held by grant_id.
- busy  out  1  state is not IDLE.
- err_timeout  out  1  one-cycle pulse when a start times out.
- bytes_sent  out  16  count of completed bytes, wraps at 0xFFFF→0.

Behaviour:
- Reset (reset_n=0 at a clock edge) forces all outputs to these values: req_ready=0, tx_start=0, tx_data=0, grant_id=0, locked=0, busy=0, err_timeout=0, bytes_sent=0. It also sets the state to IDLE, the RR pointer to 0, and clears all timers.
- Reset mid-operation drops tx_start immediately on the next edge. The byte in flight is abandoned and not counted.

State IDLE:
- Waits for tx_idle=1 and at least one candidate.
- When unlocked, the candidate is the first req_valid found searching from the RR pointer upward, wrapping modulo NUM_REQ.
- When locked, the only candidate is the lock owner; other valids are ignored.
- On a candidate: req_ready[g]=1 for exactly this cycle; capture req_data[g] into tx_data and req_last[g]; set grant_id=g; go to START.
- req_ready is never asserted in any other state.
- Accept latency is 1 cycle from a valid arriving in IDLE with tx_idle=1.
- Lock timeout: while locked, the owner's valid is low, and the state is IDLE, a counter increments. When it reaches LOCK_TIMEOUT, clear locked and set the RR pointer to owner+1. The counter resets whenever the owner's valid is high or the lock is not held.

State START:
- tx_start=1 and a timer increments.
- tx_idle=0 → tx_start=0 on the next edge, clear the timer, go to WAIT_DONE.
- Timer reaches START_TIMEOUT with tx_idle still 1 → tx_start=0, err_timeout=1 for one cycle, drop the byte, clear locked, set the RR pointer to g+1, go to IDLE. bytes_sent is unchanged.

State WAIT_DONE:
- Waits for tx_idle=1, then increments bytes_sent and updates the lock:
  - captured last=0 → locked=1 (owner g), RR pointer unchanged.
  - captured last=1 → locked=0, RR pointer = g+1 mod NUM_REQ.
- Then go to IDLE. The next accept can occur on the following cycle at the earliest.
- tx_idle glitching high in START before falling is not allowed. A glitch in WAIT_DONE counts as completion.

Other rules:
- busy=1 in START and WAIT_DONE.
- Simultaneous valids: only one grant per byte. Fairness is that every waiting requester is served within NUM_REQ messages.
- The RR pointer and grant_id widths are $clog2(NUM_REQ). Pointer increments wrap modulo NUM_REQ, including for non-power-of-two NUM_REQ.

Test Plan:
- Single byte: req 2 valid with data 0x41, last=1, TX model drops idle for 10 cycles. Required: req_ready=0b0100 for one cycle, tx_data=0x41, tx_start high until idle falls, bytes_sent=1, grant_id=2, locked=0.
- Fairness: all 4 requesters hold valid with last=1. Required: accept order 0,1,2,3,0, bytes_sent=5, each req_ready one-hot.
- Lock: req 1 sends "AB" (last=0,1) while req 0 and req 3 are valid. Required: tx_data sequence 0x41, 0x42 from req 1 back-to-back, locked=1 between them, then req 3 served next.
- Start timeout with START_TIMEOUT=16: TX model keeps idle high. Required: tx_start high for 16 cycles, err_timeout pulses once, bytes_sent unchanged, back in IDLE with busy=0.
- Lock timeout with LOCK_TIMEOUT=8: req 0 sends last=0 then drops valid while req 2 is valid. Required: locked clears after 8 idle cycles and req 2 is accepted.
- Reset mid-byte: assert reset_n=0 in WAIT_DONE. Required: next edge tx_start=0, busy=0, bytes_sent=0, locked=0; a following request is accepted normally.
